// File: rtl/gray_mon_pkg.sv
// Shared types and constants for the Gray-code monitor: FSM state encoding
// and active-low seven-segment glyphs ordered {g,f,e,d,c,b,a}.
package gray_mon_pkg;

   typedef enum logic {
      PRIME = 1'b0,
      TRACK = 1'b1
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ERR   = 7'h06;

   // Hex glyphs 0..F, active-low.
   localparam logic [6:0] SEG_GLYPH [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/gray_monitor_gray2bin.sv
// Purely combinational Gray-to-binary decoder. Each binary bit is the XOR
// of all Gray bits at or above its position, which avoids a bit-serial chain.
module gray2bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign bin[gi] = ^gray[WIDTH-1:gi];
      end
   endgenerate

endmodule

// File: rtl/gray_monitor.sv
// Gray-code monitor: synchronises and debounces an asynchronous Gray bus,
// decodes it, and classifies each accepted change as step-up, step-down or
// illegal, with a sticky error flag and a saturating error counter.
// Optional seven-segment output is enabled by defining GRAY_MON_SEG_EN;
// without it seg_n is tied to the blank pattern.
module gray_monitor
   import gray_mon_pkg::*;
#(
   parameter int WIDTH         = 3,
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 err_clr,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 valid,
   output logic                 step_up,
   output logic                 step_dn,
   output logic                 err_pulse,
   output logic                 err_flag,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [6:0]           seg_n
);

   localparam int                   RUN_W    = 4;
   localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(SETTLE_CYCLES - 1);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

   // Synchroniser; fill flags mark when sync2_reg holds a real sample
   // rather than its reset value, so reset contents are never accepted.
   logic [WIDTH-1:0] sync1_reg, sync2_reg;
   logic             fill1_reg, fill2_reg;

   // Stability filter.
   logic [WIDTH-1:0] cand_reg;
   logic             cand_vld_reg;
   logic [RUN_W-1:0] run_reg;
   logic             stable;

   // Decoded candidate and its distance from the last accepted value.
   logic [WIDTH-1:0] cand_bin;
   logic [WIDTH-1:0] diff;

   // FSM and output registers.
   state_t               state_reg, state_next;
   logic [WIDTH-1:0]     bin_reg, bin_next;
   logic                 valid_reg, valid_next;
   logic                 up_reg, up_next;
   logic                 dn_reg, dn_next;
   logic                 errp_reg, errp_next;
   logic                 flag_reg, flag_next;
   logic [ERR_CNT_W-1:0] cnt_reg, cnt_next;

   // Two-flop synchroniser for the asynchronous Gray bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         fill1_reg <= 1'b0;
         fill2_reg <= 1'b0;
      end else begin
         sync1_reg <= gray_in;
         sync2_reg <= sync1_reg;
         fill1_reg <= 1'b1;
         fill2_reg <= fill1_reg;
      end
   end

   // Candidate/run-length filter: any differing sample restarts the run.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand_reg     <= '0;
         cand_vld_reg <= 1'b0;
         run_reg      <= '0;
      end else if (fill2_reg) begin
         if (!cand_vld_reg || (sync2_reg != cand_reg)) begin
            cand_reg     <= sync2_reg;
            cand_vld_reg <= 1'b1;
            run_reg      <= '0;
         end else if (run_reg != RUN_LAST) begin
            run_reg <= run_reg + RUN_W'(1);
         end
      end
   end

   // The run counter saturates, so a steady candidate stays "stable" and
   // the FSM filters repeats by comparing against the accepted value.
   assign stable = fill2_reg && cand_vld_reg && (sync2_reg == cand_reg)
                   && (run_reg == RUN_LAST);

   gray2bin #(
      .WIDTH (WIDTH)
   ) u_gray2bin (
      .gray (cand_reg),
      .bin  (cand_bin)
   );

   assign diff = cand_bin - bin_reg;

   // State and output register bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= PRIME;
         bin_reg   <= '0;
         valid_reg <= 1'b0;
         up_reg    <= 1'b0;
         dn_reg    <= 1'b0;
         errp_reg  <= 1'b0;
         flag_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         bin_reg   <= bin_next;
         valid_reg <= valid_next;
         up_reg    <= up_next;
         dn_reg    <= dn_next;
         errp_reg  <= errp_next;
         flag_reg  <= flag_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state and classification; an error on the same cycle as err_clr
   // counts from zero, so the error wins over the clear.
   always_comb begin
      state_next = state_reg;
      bin_next   = bin_reg;
      valid_next = valid_reg;
      up_next    = 1'b0;
      dn_next    = 1'b0;
      errp_next  = 1'b0;
      flag_next  = err_clr ? 1'b0 : flag_reg;
      cnt_next   = err_clr ? '0 : cnt_reg;
      case (state_reg)
         PRIME: begin
            if (stable) begin
               bin_next   = cand_bin;
               valid_next = 1'b1;
               state_next = TRACK;
            end
         end
         TRACK: begin
            if (stable && (cand_bin != bin_reg)) begin
               bin_next = cand_bin;
               if (diff == WIDTH'(1)) begin
                  up_next = 1'b1;
               end else if (diff == {WIDTH{1'b1}}) begin
                  dn_next = 1'b1;
               end else begin
                  errp_next = 1'b1;
                  flag_next = 1'b1;
                  if (cnt_next != CNT_MAX) begin
                     cnt_next = cnt_next + ERR_CNT_W'(1);
                  end
               end
            end
         end
         default: state_next = PRIME;
      endcase
   end

   assign bin_out   = bin_reg;
   assign valid     = valid_reg;
   assign step_up   = up_reg;
   assign step_dn   = dn_reg;
   assign err_pulse = errp_reg;
   assign err_flag  = flag_reg;
   assign err_count = cnt_reg;

`ifdef GRAY_MON_SEG_EN
   logic [6:0] seg_reg;
   logic [3:0] nib;

   assign nib = 4'(bin_reg);

   // Glyph register trails bin_out by one cycle; error overrides the digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_reg <= SEG_BLANK;
      end else if (!valid_reg) begin
         seg_reg <= SEG_BLANK;
      end else if (flag_reg) begin
         seg_reg <= SEG_ERR;
      end else begin
         seg_reg <= SEG_GLYPH[nib];
      end
   end

   assign seg_n = seg_reg;
`else
   assign seg_n = SEG_BLANK;
`endif

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor at default parameters. Stimulus pushes
// hand-computed expected events; a negedge monitor pops and compares them.
module tb_gray_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] gray_in;
   logic       err_clr;
   logic [2:0] bin_out;
   logic       valid, step_up, step_dn, err_pulse, err_flag;
   logic [7:0] err_count;
   logic [6:0] seg_n;

   localparam logic [2:0] K_UP = 3'b100;
   localparam logic [2:0] K_DN = 3'b010;
   localparam logic [2:0] K_ER = 3'b001;

`ifdef GRAY_MON_SEG_EN
   localparam logic [6:0] SEG_THREE = 7'h30;
   localparam logic [6:0] SEG_E     = 7'h06;
`else
   localparam logic [6:0] SEG_THREE = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h7F;
`endif

   typedef struct {
      logic [2:0] kind;
      logic [2:0] bin;
      logic       flag;
      logic [7:0] cnt;
      int         cyc;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_up     = 0;
   int   cyc      = 0;
   logic       m_flag = 1'b0;
   logic [7:0] m_cnt  = 8'd0;

   gray_monitor dut (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .err_clr   (err_clr),
      .bin_out   (bin_out),
      .valid     (valid),
      .step_up   (step_up),
      .step_dn   (step_dn),
      .err_pulse (err_pulse),
      .err_flag  (err_flag),
      .err_count (err_count),
      .seg_n     (seg_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Monitor: every output pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (step_up || step_dn || err_pulse) begin
         if (step_up) n_up++;
         if (sbq.size() == 0) begin
            chk("unexpected_event", {29'd0, step_up, step_dn, err_pulse}, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("ev_kind",  {29'd0, step_up, step_dn, err_pulse}, {29'd0, e.kind});
            chk("ev_bin",   {29'd0, bin_out}, {29'd0, e.bin});
            chk("ev_flag",  {31'd0, err_flag}, {31'd0, e.flag});
            chk("ev_count", {24'd0, err_count}, {24'd0, e.cnt});
            chk("ev_cycle", cyc, e.cyc);
            $display("event kind=%b bin=%0d flag=%0d cnt=%0d cyc=%0d",
                     {step_up, step_dn, err_pulse}, bin_out, err_flag, err_count, cyc);
         end
      end
   end

   // Drive a new Gray value, predict its event, hold for 'hold' cycles;
   // optionally assert err_clr on the acceptance edge.
   task automatic apply(input logic [2:0] g, input logic [2:0] kind,
                        input logic [2:0] bin, input int hold, input bit clr_hit);
      exp_t e;
      @(negedge clk);
      gray_in = g;
      if (kind == K_ER) begin
         m_flag = 1'b1;
         if (clr_hit) m_cnt = 8'd1;
         else if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      e.kind = kind;
      e.bin  = bin;
      e.flag = m_flag;
      e.cnt  = m_cnt;
      e.cyc  = cyc + 1 + 4;
      sbq.push_back(e);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         err_clr = clr_hit && (i == 4);
      end
      err_clr = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_bin"},   {29'd0, bin_out}, 32'd0);
      chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
      chk({tag, "_pulses"}, {29'd0, step_up, step_dn, err_pulse}, 32'd0);
      chk({tag, "_flag"},  {31'd0, err_flag}, 32'd0);
      chk({tag, "_count"}, {24'd0, err_count}, 32'd0);
      chk({tag, "_seg"},   {25'd0, seg_n}, 32'h7F);
   endtask

   logic [2:0] up_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
   logic [2:0] up_b [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

   initial begin
      rst = 1'b1;
      gray_in = 3'b000;
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("prime_valid", {31'd0, valid}, 32'd1);
      chk("prime_bin", {29'd0, bin_out}, 32'd0);

      // Full upward cycle including 7->0 wrap.
      for (int i = 0; i < 8; i++) apply(up_g[i], K_UP, up_b[i], 10, 1'b0);
      chk("up_count", n_up, 8);

      // Downward with 0->7 wrap, then back up to 1.
      apply(3'b100, K_DN, 3'd7, 10, 1'b0);
      apply(3'b101, K_DN, 3'd6, 10, 1'b0);
      chk("dn_no_err", {31'd0, err_flag}, 32'd0);
      apply(3'b100, K_UP, 3'd7, 6, 1'b0);
      apply(3'b000, K_UP, 3'd0, 6, 1'b0);
      apply(3'b001, K_UP, 3'd1, 6, 1'b0);

      // Single-bit Gray change 1->6 is still illegal.
      apply(3'b101, K_ER, 3'd6, 6, 1'b0);
      chk("err_first_flag", {31'd0, err_flag}, 32'd1);
      chk("err_first_count", {24'd0, err_count}, 32'd1);

      // Saturation of the counter.
      for (int i = 1; i <= 300; i++)
         apply((i % 2) ? 3'b001 : 3'b101, K_ER, (i % 2) ? 3'd1 : 3'd6, 5, 1'b0);
      repeat (2) @(negedge clk);
      chk("sat_count", {24'd0, err_count}, 32'd255);
      chk("sat_flag", {31'd0, err_flag}, 32'd1);
      chk("seg_err", {25'd0, seg_n}, {25'd0, SEG_E});

      // Clear alone.
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_flag = 1'b0;
      m_cnt  = 8'd0;
      chk("clr_flag", {31'd0, err_flag}, 32'd0);
      chk("clr_count", {24'd0, err_count}, 32'd0);

      // Walk down 6->2.
      apply(3'b111, K_DN, 3'd5, 6, 1'b0);
      apply(3'b110, K_DN, 3'd4, 6, 1'b0);
      apply(3'b010, K_DN, 3'd3, 6, 1'b0);
      apply(3'b011, K_DN, 3'd2, 6, 1'b0);

      // One-cycle glitch is rejected.
      @(negedge clk);
      gray_in = 3'b111;
      @(negedge clk);
      gray_in = 3'b011;
      repeat (8) @(negedge clk);
      chk("glitch_bin", {29'd0, bin_out}, 32'd2);
      chk("glitch_flag", {31'd0, err_flag}, 32'd0);

      // Three-cycle hold is accepted (2->5 illegal), then back (5->2 illegal).
      apply(3'b111, K_ER, 3'd5, 3, 1'b0);
      apply(3'b011, K_ER, 3'd2, 8, 1'b0);
      chk("hold3_count", {24'd0, err_count}, 32'd2);

      // err_clr coincident with an illegal acceptance: error wins.
      apply(3'b101, K_ER, 3'd6, 8, 1'b1);
      chk("clr_hit_flag", {31'd0, err_flag}, 32'd1);
      chk("clr_hit_count", {24'd0, err_count}, 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_flag = 1'b0;
      m_cnt  = 8'd0;
      chk("clr_next_flag", {31'd0, err_flag}, 32'd0);
      chk("clr_next_count", {24'd0, err_count}, 32'd0);

      // Walk down 6->3 and check the digit.
      apply(3'b111, K_DN, 3'd5, 6, 1'b0);
      apply(3'b110, K_DN, 3'd4, 6, 1'b0);
      apply(3'b010, K_DN, 3'd3, 6, 1'b0);
      repeat (2) @(negedge clk);
      chk("seg_three", {25'd0, seg_n}, {25'd0, SEG_THREE});

      // Reset during a pending change; the held value then primes silently.
      @(negedge clk);
      gray_in = 3'b110;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_state("midrst");
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("reprime_valid", {31'd0, valid}, 32'd1);
      chk("reprime_bin", {29'd0, bin_out}, 32'd4);
      chk("reprime_flag", {31'd0, err_flag}, 32'd0);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
